// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_pkg
//  Description : Shared PPU types and timing constants for the background
//                fetch path (fetch state enum, VRAM bases, dot/line marks).
//  Revision    : 1.0 - initial release
// ============================================================================
package ppu_pkg;

    // Fetch sequencer states: *_A = address issued, *_D = data being latched
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        NT_A = 4'd1,
        NT_D = 4'd2,
        AT_A = 4'd3,
        AT_D = 4'd4,
        PL_A = 4'd5,
        PL_D = 4'd6,
        PH_A = 4'd7,
        PH_D = 4'd8
    } bg_fetch_state_t;

    localparam logic [13:0] NT_BASE           = 14'h2000;
    localparam logic [13:0] AT_BASE           = 14'h23C0;
    localparam logic [8:0]  DOT_HCOPY         = 9'd257;
    localparam logic [8:0]  DOT_YINC          = 9'd256;
    localparam logic [8:0]  PRERENDER_LINE    = 9'd261;
    localparam logic [8:0]  VCOPY_FIRST       = 9'd280;
    localparam logic [8:0]  VCOPY_LAST        = 9'd304;
    localparam logic [8:0]  LAST_VISIBLE_LINE = 9'd239;
    localparam logic [8:0]  FETCH_FIRST       = 9'd1;
    localparam logic [8:0]  PREFETCH_FIRST    = 9'd321;
    localparam logic [8:0]  PREFETCH_LAST     = 9'd336;

endpackage : ppu_pkg
`default_nettype wire

// File: rtl/loopy_v_reg.sv
`default_nettype none
// ============================================================================
//  Module      : loopy_v_reg
//  Description : Scroll address register v with coarse-X / Y increments and
//                horizontal / vertical copies from the t latch. Strobes are
//                already qualified with the dot enable by the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module loopy_v_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_x,
    input  logic        inc_y,
    input  logic        copy_h,
    input  logic        copy_v,
    input  logic [14:0] t_reg,
    output logic [14:0] v_reg
);

    logic [14:0] r_v;
    logic [14:0] w_v_next;

    // Next-v: increments touch disjoint fields, so both may apply on one edge
    always_comb begin
        w_v_next = r_v;
        if (inc_x) begin
            if (r_v[4:0] == 5'd31) begin
                w_v_next[4:0] = 5'd0;
                w_v_next[10]  = ~r_v[10];
            end else begin
                w_v_next[4:0] = r_v[4:0] + 5'd1;
            end
        end
        if (inc_y) begin
            if (r_v[14:12] != 3'd7) begin
                w_v_next[14:12] = r_v[14:12] + 3'd1;
            end else begin
                w_v_next[14:12] = 3'd0;
                case (r_v[9:5])
                    5'd29: begin
                        w_v_next[9:5] = 5'd0;
                        w_v_next[11]  = ~r_v[11];
                    end
                    // rows 30/31 hold attribute data; wrap without a toggle
                    5'd31:   w_v_next[9:5] = 5'd0;
                    default: w_v_next[9:5] = r_v[9:5] + 5'd1;
                endcase
            end
        end
        if (copy_h) begin
            w_v_next[10]  = t_reg[10];
            w_v_next[4:0] = t_reg[4:0];
        end
        if (copy_v) begin
            w_v_next[14:11] = t_reg[14:11];
            w_v_next[9:5]   = t_reg[9:5];
        end
    end

    // Register v
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v <= 15'd0;
        end else begin
            r_v <= w_v_next;
        end
    end

    assign v_reg = r_v;

endmodule : loopy_v_reg
`default_nettype wire

// File: rtl/bg_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bg_fetch_sequencer
//  Description : PPU background fetch sequencer. Walks the 8-dot NT / AT /
//                pattern-lo / pattern-hi fetch group, drives VRAM reads,
//                latches returned bytes and pulses the shift-register load.
//  Revision    : 1.0 - initial release
// ============================================================================
module bg_fetch_sequencer
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dot_en,
    input  logic        render_en,
    input  logic [8:0]  dot,
    input  logic [8:0]  scanline,
    input  logic [14:0] t_reg,
    input  logic        bg_pt_sel,
    input  logic [7:0]  vram_rdata,
    output logic [13:0] vram_addr,
    output logic        vram_rd,
    output logic [7:0]  nt_byte,
    output logic [1:0]  at_bits,
    output logic [7:0]  pt_lo,
    output logic [7:0]  pt_hi,
    output logic        shift_load,
    output logic [14:0] v_reg
);

    bg_fetch_state_t r_state;
    logic [13:0]     r_vram_addr;
    logic            r_vram_rd;
    logic [7:0]      r_nt_byte;
    logic [1:0]      r_at_bits;
    logic [7:0]      r_pt_lo;
    logic [7:0]      r_pt_hi;
    logic            r_shift_load;

    logic [14:0] w_v;
    logic        w_fetch_line;
    logic        w_render_line;
    logic        w_fetch_dot;
    logic        w_in_group;
    logic [2:0]  w_phase;
    logic [13:0] w_nt_addr;
    logic [13:0] w_at_addr;
    logic [13:0] w_pt_addr;
    logic [7:0]  w_at_shifted;
    logic        w_inc_x;
    logic        w_inc_y;
    logic        w_copy_h;
    logic        w_copy_v;

    assign w_fetch_line  = (scanline <= LAST_VISIBLE_LINE) || (scanline == PRERENDER_LINE);
    assign w_render_line = render_en && w_fetch_line;
    assign w_fetch_dot   = w_render_line &&
                           (((dot >= FETCH_FIRST) && (dot <= DOT_YINC)) ||
                            ((dot >= PREFETCH_FIRST) && (dot <= PREFETCH_LAST)));
    assign w_phase       = dot[2:0];
    // PH_D is the resting state between groups, not part of an open fetch
    assign w_in_group    = (r_state != IDLE) && (r_state != PH_D);

    assign w_nt_addr    = NT_BASE | {2'b00, w_v[11:0]};
    assign w_at_addr    = AT_BASE | {2'b00, w_v[11:10], 4'b0000, w_v[9:7], w_v[4:2]};
    assign w_pt_addr    = {1'b0, bg_pt_sel, r_nt_byte, 1'b0, w_v[14:12]};
    // Quadrant select inside the attribute byte: {coarseY bit 1, coarseX bit 1}
    assign w_at_shifted = vram_rdata >> {w_v[6], w_v[1], 1'b0};

    assign w_inc_x  = dot_en && (r_state == PH_A) && w_fetch_dot;
    assign w_inc_y  = dot_en && w_render_line && (dot == DOT_YINC);
    assign w_copy_h = dot_en && w_render_line && (dot == DOT_HCOPY);
    assign w_copy_v = dot_en && render_en && (scanline == PRERENDER_LINE) &&
                      (dot >= VCOPY_FIRST) && (dot <= VCOPY_LAST);

    loopy_v_reg u_loopy_v_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_x  (w_inc_x),
        .inc_y  (w_inc_y),
        .copy_h (w_copy_h),
        .copy_v (w_copy_v),
        .t_reg  (t_reg),
        .v_reg  (w_v)
    );

    // Fetch FSM with registered VRAM request, data latches and load pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_vram_addr  <= 14'd0;
            r_vram_rd    <= 1'b0;
            r_nt_byte    <= 8'd0;
            r_at_bits    <= 2'd0;
            r_pt_lo      <= 8'd0;
            r_pt_hi      <= 8'd0;
            r_shift_load <= 1'b0;
        end else begin
            r_shift_load <= 1'b0;
            if (dot_en) begin
                if (w_in_group && !w_fetch_dot) begin
                    // Rendering dropped mid-group: abandon it, latches hold
                    r_state   <= IDLE;
                    r_vram_rd <= 1'b0;
                end else begin
                    case (r_state)
                        IDLE, PH_D: begin
                            if (w_fetch_dot && (w_phase == 3'd1)) begin
                                r_state     <= NT_A;
                                r_vram_addr <= w_nt_addr;
                                r_vram_rd   <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                            end
                        end
                        NT_A: begin
                            r_nt_byte <= vram_rdata;
                            r_state   <= NT_D;
                        end
                        NT_D: begin
                            r_vram_addr <= w_at_addr;
                            r_state     <= AT_A;
                        end
                        AT_A: begin
                            r_at_bits <= w_at_shifted[1:0];
                            r_state   <= AT_D;
                        end
                        AT_D: begin
                            r_vram_addr <= w_pt_addr;
                            r_state     <= PL_A;
                        end
                        PL_A: begin
                            r_pt_lo <= vram_rdata;
                            r_state <= PL_D;
                        end
                        PL_D: begin
                            r_vram_addr <= r_vram_addr + 14'd8;
                            r_state     <= PH_A;
                        end
                        PH_A: begin
                            r_pt_hi      <= vram_rdata;
                            r_vram_rd    <= 1'b0;
                            r_shift_load <= 1'b1;
                            r_state      <= PH_D;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign vram_addr  = r_vram_addr;
    assign vram_rd    = r_vram_rd;
    assign nt_byte    = r_nt_byte;
    assign at_bits    = r_at_bits;
    assign pt_lo      = r_pt_lo;
    assign pt_hi      = r_pt_hi;
    assign shift_load = r_shift_load;
    assign v_reg      = w_v;

endmodule : bg_fetch_sequencer
`default_nettype wire

// File: doc/bg_fetch_sequencer.md
# bg_fetch_sequencer

Background fetch sequencer for the PPU. Walks the 8-dot nametable, attribute, pattern-low and pattern-high fetch cycle on rendering scanlines and drives the VRAM read address and strobe. Latches the returned bytes and pulses the load strobe for the background tile shift registers. Owns the scroll address register `v`: coarse-X and Y increments, plus horizontal and vertical copies from `t`. Sits between the dot/scanline timing generator (advanced by a clock_div enable) and the background shift registers.

## Interface
- No parameters.

- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `dot_en` in 1: one-`clk` pulse per PPU dot.
- `render_en` in 1: background or sprite rendering enabled.
- `dot` in 9: current dot, 0–340, stable between `dot_en` pulses.
- `scanline` in 9: current scanline, 0–261.
- `t_reg` in 15: scroll latch `t`, with bit layout {fineY[2:0], nt[1:0], coarseY[4:0], coarseX[4:0]}.
- `bg_pt_sel` in 1: background pattern table select.
- `vram_rdata` in 8: VRAM read data, valid by the `dot_en` edge following the request.
- `vram_addr` out 14: VRAM read address.
- `vram_rd` out 1: read strobe.
- `nt_byte` out 8: latched nametable byte (tile index).
- `at_bits` out 2: palette bits for the current tile.
- `pt_lo` out 8: latched pattern-low byte.
- `pt_hi` out 8: latched pattern-high byte.
- `shift_load` out 1: one-`clk` pulse to load the shift registers.
- `v_reg` out 15: current `v`.

## Operation
- All actions occur only on `clk` edges where `dot_en`=1. These are called "dot edges".
- A fetch line is any scanline 0–239, or scanline 261.
- A fetch dot is any dot 1–256 or 321–336 on a fetch line, with `render_en`=1.
- Phase is `dot[2:0]`.
- FSM states:
  - IDLE
  - NT_A, NT_D
  - AT_A, AT_D
  - PL_A, PL_D
  - PH_A, PH_D
- FSM transitions:
  - IDLE goes to NT_A only on a fetch-dot edge with phase 1.
  - Each state then advances one per dot edge, in the order listed above.
  - PH_D goes to NT_A if the next dot is a fetch dot; otherwise it goes to IDLE.
- Fetch actions by phase:
  - Phase 1: `vram_addr` = 0x2000 | v[11:0], `vram_rd`=1.
  - Phase 2: `nt_byte` <= `vram_rdata`.
  - Phase 3: `vram_addr` = 0x23C0 | v[11:10]<<10 | v[9:7]<<3 | v[4:2].
  - Phase 4: `at_bits` <= (`vram_rdata` >> {v[6], v[1], 1'b0})[1:0].
  - Phase 5: `vram_addr` = `bg_pt_sel`<<12 | `nt_byte`<<4 | v[14:12].
  - Phase 6: `pt_lo` <= `vram_rdata`.
  - Phase 7: `vram_addr` is the phase-5 address + 8.
  - Phase 0: `pt_hi` <= `vram_rdata`, `vram_rd`=0.
  - `vram_rd` stays 1 from the phase-1 edge through the phase-0 edge.
- `v` updates, only when `render_en`=1 on a fetch line:
  - Coarse-X increment on the phase-0 edge of every fetch group. When coarseX=31: coarseX=0 and toggle v[10].
  - Y increment at dot 256:
    - If fineY<7, increment fineY.
    - Otherwise fineY=0, then:
      - coarseY=29: coarseY=0 and toggle v[11].
      - coarseY=31: coarseY=0, no toggle.
      - Any other coarseY: increment coarseY.
  - Horizontal copy at dot 257: v[10] and v[4:0] <= `t_reg`.
  - Vertical copy on scanline 261, dots 280–304: v[14:11] and v[9:5] <= `t_reg`.
- Dot 256 applies both the coarse-X increment and the Y increment on the same edge. Their fields are disjoint, so both results land.
- `render_en` falls mid-group:
  - The FSM goes to IDLE on the next dot edge and `vram_rd`=0.
  - Latches and `v` hold.
  - No `shift_load` is issued for the partial group.
- Reset takes priority over `dot_en`. Every output and `v` resets to 0 and the FSM goes to IDLE.

## Timing
- `vram_addr` and `vram_rd` are registered and change 1 `clk` after a dot edge.
- Memory latency is 1 dot.
- `shift_load` asserts 1 `clk` after the phase-0 dot edge, for exactly one `clk`. At that point `pt_lo`, `pt_hi` and `at_bits` are stable.
- `v_reg` is updated on the dot edge; no extra latency.

## Structure
- Shared package `ppu_pkg` holds:
  - the FSM state enum `bg_fetch_state_t`;
  - constants `NT_BASE`=14'h2000, `AT_BASE`=14'h23C0, `DOT_HCOPY`=257, `DOT_YINC`=256, `PRERENDER_LINE`=261, `VCOPY_FIRST`=280, `VCOPY_LAST`=304.
- Sub-module `loopy_v_reg` holds `v` with the increment and copy logic. Its inputs are: inc_x, inc_y, copy_h, copy_v, `t_reg`.

## Test plan
- Basic fetch: `v`=0, scanline 0, `bg_pt_sel`=1, NT data 0x24 → `vram_addr` sequence 0x2000, 0x23C0, 0x1240, 0x1248 → `shift_load` pulse after dot 8 → `v_reg`=0x0001.
- Coarse-X wrap: `v`=0x001F at dot 8 → `v_reg`=0x0400.
- Y wrap: `v`=0x73A0 at dot 256 → `v_reg`=0x0801.
- Attribute select: AT byte 0xE4:
  - coarseX=2, coarseY=2 → `at_bits`=3.
  - coarseX=2, coarseY=0 → `at_bits`=1.
- Copies: `t_reg`=0x7FFF, scanline 261 → dot 257 sets bits 10 and 4:0 of `v`; dot 280 sets the vertical bits; `v_reg`=0x7FFF.
- Abort: `render_en` dropped at dot 4 → next edge `vram_rd`=0, FSM IDLE, no `shift_load`, `v` unchanged.
- Reset: `rst_n` low mid-group → all outputs 0 on the next `clk`.
